// File: rtl/msi_cpu_controller_pkg.sv
// msi_cpu_controller_pkg: bus command codes, MSI line states and the controller FSM states
package commands;
  localparam int COMMAND_WIDTH = 2;
  localparam logic [COMMAND_WIDTH-1:0] NONE              = 2'd0;
  localparam logic [COMMAND_WIDTH-1:0] BUS_READ          = 2'd1;
  localparam logic [COMMAND_WIDTH-1:0] BUS_READEXCLUSIVE = 2'd2;
  localparam logic [COMMAND_WIDTH-1:0] BUS_INVALIDATE    = 2'd3;
endpackage

package MSIStates;
  localparam int STATE_WIDTH = 2;
  localparam logic [STATE_WIDTH-1:0] INVALID  = 2'd0;
  localparam logic [STATE_WIDTH-1:0] SHARED   = 2'd1;
  localparam logic [STATE_WIDTH-1:0] MODIFIED = 2'd2;
endpackage

package msi_cpu_controller_pkg;
  typedef enum logic [2:0] {IDLE, ARBITRATE, WRITE_BACK, FILL, INVALIDATE, ACCESS} ctrl_state_e;
endpackage

// File: rtl/msi_cpu_controller.sv
// msi_cpu_controller: CPU-side miss/upgrade sequencer of a snoopy MSI cache.
// Ports: CPU request/complete (cpu*), cache array word/tag/state access (cache*),
// bus arbitration and snoop command (bus*), word-wise RAM transfer (ram*).
// Strobes are decoded from the current state so that per-word cache writes line up
// with the ramAck that delivers the word.
module msi_cpu_controller
  import commands::*;
  import MSIStates::*;
  import msi_cpu_controller_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int OFFSET_WIDTH  = 2,
  parameter int INDEX_WIDTH   = 4,
  localparam int TAG_WIDTH    = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpuRead,
  input  logic                     cpuWrite,
  input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
  input  logic [DATA_WIDTH-1:0]    cpuDataOut,
  output logic                     cpuFunctionComplete,
  input  logic                     cpuHit,
  input  logic                     writeBackRequired,
  input  logic                     invalidateRequired,
  input  logic [STATE_WIDTH-1:0]   protocolStateIn,
  input  logic [TAG_WIDTH-1:0]     cacheTagOut,
  input  logic [DATA_WIDTH-1:0]    cacheDataOut,
  output logic [OFFSET_WIDTH-1:0]  cacheOffset,
  output logic [DATA_WIDTH-1:0]    cacheDataIn,
  output logic                     cacheDataWrite,
  output logic                     cacheTagWrite,
  output logic                     cacheStateWrite,
  output logic [STATE_WIDTH-1:0]   cacheStateIn,
  output logic                     busRequest,
  input  logic                     busGrant,
  output logic [COMMAND_WIDTH-1:0] busCommand,
  output logic [ADDRESS_WIDTH-1:0] busAddress,
  output logic [ADDRESS_WIDTH-1:0] ramAddress,
  output logic                     ramRead,
  output logic                     ramWrite,
  output logic [DATA_WIDTH-1:0]    ramDataOut,
  input  logic                     ramDataIn_unused_guard,
  input  logic [DATA_WIDTH-1:0]    ramDataIn,
  input  logic                     ramAck
);
  ctrl_state_e state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic write_q, write_d;
  logic req, last, wb, fl, inv, acc, tag_wr;
  assign req  = cpuRead | cpuWrite;
  assign last = &cnt_q;
  assign wb   = state_q == WRITE_BACK;
  assign fl   = state_q == FILL;
  assign inv  = state_q == INVALIDATE;
  assign acc  = state_q == ACCESS;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d  = cpuAddress;
        write_d = cpuWrite;
        state_d = (cpuHit && !invalidateRequired) ? ACCESS : ARBITRATE;
      end
      // Hit/invalidate are re-sampled at grant: a snoop may have taken the line meanwhile.
      ARBITRATE: if (busGrant) state_d = cpuHit ? (invalidateRequired ? INVALIDATE : ACCESS)
                                                : (writeBackRequired ? WRITE_BACK : FILL);
      // The counter wraps on the last word, so the fill starts again at word 0.
      WRITE_BACK, FILL: if (ramAck) begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = wb ? FILL : ACCESS;
      end
      INVALIDATE: state_d = ACCESS;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
    end
  end
  assign tag_wr              = fl && ramAck && last;
  assign busRequest          = wb || fl || inv || state_q == ARBITRATE;
  assign busCommand          = fl ? (write_q ? BUS_READEXCLUSIVE : BUS_READ) : inv ? BUS_INVALIDATE : NONE;
  assign busAddress          = (fl || inv) ? {addr_q[ADDRESS_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}} : '0;
  assign ramAddress          = wb ? {cacheTagOut, addr_q[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH], cnt_q}
                             : fl ? {addr_q[ADDRESS_WIDTH-1:OFFSET_WIDTH], cnt_q} : '0;
  assign ramRead             = fl;
  assign ramWrite            = wb;
  assign ramDataOut          = cacheDataOut;
  assign cacheOffset         = acc ? addr_q[OFFSET_WIDTH-1:0] : cnt_q;
  assign cacheDataWrite      = (fl && ramAck) || (acc && write_q);
  assign cacheDataIn         = fl ? ramDataIn : acc ? cpuDataOut : '0;
  assign cacheTagWrite       = tag_wr;
  assign cacheStateWrite     = tag_wr || (acc && write_q);
  assign cacheStateIn        = tag_wr ? (write_q ? MODIFIED : SHARED) : (acc && write_q) ? protocolStateIn : INVALID;
  assign cpuFunctionComplete = acc;
endmodule

// File: tb/tb_msi_cpu_controller.sv
// tb_msi_cpu_controller: table vectors, corner sequences and random transactions against a transaction-level model
module tb_msi_cpu_controller;
  import commands::*;
  import MSIStates::*;
  typedef logic [17:0] q_t [$];
  typedef struct {
    bit wr; bit both; logic [15:0] addr;
    bit hit0; bit inv0; bit hitg; bit invg; bit wb;
    logic [9:0] vtag; int gdly; bit rand_ack;
  } txn_t;
  typedef struct {
    txn_t t; logic [1:0] e_cmd; int e_nwb; int e_nfill; logic [15:0] e_word; bit chk_word;
  } vec_t;
  logic clock, reset, cpuRead, cpuWrite, cpuFunctionComplete, cpuHit, writeBackRequired, invalidateRequired;
  logic [15:0] cpuAddress, cpuDataOut, cacheDataOut, cacheDataIn, busAddress, ramAddress, ramDataOut, ramDataIn;
  logic [1:0] protocolStateIn, cacheOffset, cacheStateIn, busCommand;
  logic [9:0] cacheTagOut;
  logic cacheDataWrite, cacheTagWrite, cacheStateWrite, busRequest, busGrant, ramRead, ramWrite, ramAck;
  logic [15:0] cmem [4] = '{16'h5550, 16'h5551, 16'h5552, 16'h5553};
  logic [15:0] snap [4];
  int pass_cnt = 0, total_cnt = 0;
  q_t wb_log, rd_log, dw_log, sw_log, cmd_log, e_wb, e_rd, e_dw, e_sw, e_cmd;
  logic [15:0] fill_data [$];
  int tw_n, e_tw, cpl_n, cpl_k, bad_addr, bad_req, br_seen;
  logic [1:0] cpl_off, e_off;
  logic [15:0] cpl_word, e_word;
  bit e_direct;
  msi_cpu_controller dut (
    .clock(clock), .reset(reset), .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress),
    .cpuDataOut(cpuDataOut), .cpuFunctionComplete(cpuFunctionComplete), .cpuHit(cpuHit),
    .writeBackRequired(writeBackRequired), .invalidateRequired(invalidateRequired),
    .protocolStateIn(protocolStateIn), .cacheTagOut(cacheTagOut), .cacheDataOut(cacheDataOut),
    .cacheOffset(cacheOffset), .cacheDataIn(cacheDataIn), .cacheDataWrite(cacheDataWrite),
    .cacheTagWrite(cacheTagWrite), .cacheStateWrite(cacheStateWrite), .cacheStateIn(cacheStateIn),
    .busRequest(busRequest), .busGrant(busGrant), .busCommand(busCommand), .busAddress(busAddress),
    .ramAddress(ramAddress), .ramRead(ramRead), .ramWrite(ramWrite), .ramDataOut(ramDataOut),
    .ramDataIn_unused_guard(1'b0), .ramDataIn(ramDataIn), .ramAck(ramAck)
  );
  assign cacheDataOut = cmem[cacheOffset];
  always @(posedge clock) if (cacheDataWrite) cmem[cacheOffset] <= cacheDataIn;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic logic [8:0] outv();
    return {busRequest, ramRead, ramWrite, cacheDataWrite, cacheTagWrite, cacheStateWrite, cpuFunctionComplete, busCommand};
  endfunction
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    total_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  task automatic cmpq(input string n, input q_t a, input q_t e);
    check({n, "_len"}, 64'(a.size()), 64'(e.size()));
    for (int i = 0; i < a.size() && i < e.size(); i++) check($sformatf("%s[%0d]", n, i), 64'(a[i]), 64'(e[i]));
  endtask
  // Transaction-level expectation: which bus command, which RAM words move, what lands in the line.
  function automatic void model(input txn_t t, input logic [15:0] wdata);
    logic [15:0] line [4];
    bit hit, upg, miss;
    logic [1:0] o;
    line = snap;
    e_wb.delete(); e_rd.delete(); e_dw.delete(); e_sw.delete(); e_cmd.delete();
    e_direct = t.hit0 && !t.inv0;
    hit  = e_direct || t.hitg;
    upg  = !e_direct && t.hitg && t.invg;
    miss = !hit;
    e_tw = 0;
    e_off = t.addr[1:0];
    if (upg) e_cmd.push_back(18'(BUS_INVALIDATE));
    if (miss) begin
      if (t.wb) for (int i = 0; i < 4; i++) begin
        o = 2'(i);
        e_wb.push_back({t.vtag, t.addr[5:2], o, o});
      end
      e_cmd.push_back(18'(t.wr ? BUS_READEXCLUSIVE : BUS_READ));
      for (int i = 0; i < 4; i++) begin
        o = 2'(i);
        e_rd.push_back({2'b00, t.addr[15:2], o});
        line[i] = i < fill_data.size() ? fill_data[i] : 16'hxxxx;
        e_dw.push_back({o, line[i]});
      end
      e_sw.push_back(18'(t.wr ? MODIFIED : SHARED));
      e_tw = 1;
    end
    e_word = line[e_off];
    if (t.wr) begin
      e_dw.push_back({e_off, wdata});
      e_sw.push_back(18'(MODIFIED));
    end
  endfunction
  task automatic run(input txn_t t);
    logic [1:0] prev_cmd;
    logic [15:0] wdata;
    int reqc, k;
    bit granted, done;
    wb_log.delete(); rd_log.delete(); dw_log.delete(); sw_log.delete(); cmd_log.delete(); fill_data.delete();
    tw_n = 0; cpl_n = 0; cpl_k = -1; bad_addr = 0; bad_req = 0; br_seen = 0; cpl_word = '0; cpl_off = '0;
    prev_cmd = NONE; reqc = 0; k = 0; granted = 0; done = 0;
    snap = cmem;
    wdata = 16'($urandom);
    cpuRead = !t.wr || t.both; cpuWrite = t.wr; cpuAddress = t.addr; cpuDataOut = wdata;
    cpuHit = t.hit0; invalidateRequired = t.inv0; writeBackRequired = t.wb; cacheTagOut = t.vtag;
    protocolStateIn = MODIFIED; busGrant = 1'b0; ramAck = 1'b0;
    while (!done && k < 200) begin
      @(negedge clock);
      if (ramWrite && ramAck) wb_log.push_back({ramAddress, cacheOffset});
      if (ramRead && ramAck) begin
        rd_log.push_back({2'b00, ramAddress});
        fill_data.push_back(ramDataIn);
      end
      if (cacheDataWrite) dw_log.push_back({cacheOffset, cacheDataIn});
      if (cacheStateWrite) sw_log.push_back(18'(cacheStateIn));
      if (cacheTagWrite) tw_n++;
      if (busCommand != NONE && busCommand != prev_cmd) cmd_log.push_back(18'(busCommand));
      prev_cmd = busCommand;
      if (busCommand != NONE && busAddress != {t.addr[15:2], 2'b00}) bad_addr++;
      if ((busRequest && cpuFunctionComplete) || ((ramRead || ramWrite || busCommand != NONE) && !busRequest)) bad_req++;
      if (busRequest) br_seen++;
      if (busRequest && !granted) reqc++;
      if (cpuFunctionComplete) begin
        cpl_n++; cpl_off = cacheOffset; cpl_word = cacheDataOut; cpl_k = k; done = 1;
      end
      @(posedge clock);
      #1;
      k++;
      if (done) begin
        cpuRead = 1'b0; cpuWrite = 1'b0; busGrant = 1'b0; ramAck = 1'b0;
      end else begin
        if (!granted && reqc > t.gdly) begin
          granted = 1; busGrant = 1'b1; cpuHit = t.hitg; invalidateRequired = t.invg;
        end
        ramAck = t.rand_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
        ramDataIn = t.rand_ack ? 16'($urandom) : 16'hA0 + 16'(rd_log.size());
      end
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL timeout: no completion after %0d cycles, required within 200", k);
      cpuRead = 1'b0; cpuWrite = 1'b0; busGrant = 1'b0; ramAck = 1'b0; reset = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
    end
    model(t, wdata);
    check("complete_count", 64'(cpl_n), 1);
    check("complete_offset", 64'(cpl_off), 64'(e_off));
    cmpq("writeback", wb_log, e_wb);
    cmpq("fill_read", rd_log, e_rd);
    cmpq("data_write", dw_log, e_dw);
    cmpq("state_write", sw_log, e_sw);
    cmpq("bus_cmd", cmd_log, e_cmd);
    check("tag_write", 64'(tw_n), 64'(e_tw));
    check("bus_addr_errors", 64'(bad_addr), 0);
    check("bus_request_errors", 64'(bad_req), 0);
    if (!t.wr) check("read_word", 64'(cpl_word), 64'(e_word));
    if (e_direct) begin
      check("hit_latency", 64'(cpl_k), 1);
      check("hit_no_busreq", 64'(br_seen), 0);
    end
  endtask
  initial begin
    vec_t tbl [7];
    txn_t r;
    int n;
    tbl[0] = '{'{1'b0, 1'b0, 16'h0042, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 0, 1'b0}, NONE, 0, 0, 16'h5552, 1'b1};
    tbl[1] = '{'{1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 3, 1'b0}, BUS_READ, 0, 4, 16'h00A3, 1'b1};
    tbl[2] = '{'{1'b1, 1'b0, 16'h0456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h012, 1, 1'b0}, BUS_READEXCLUSIVE, 4, 4, 16'h0000, 1'b0};
    tbl[3] = '{'{1'b1, 1'b0, 16'h0789, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 2, 1'b0}, BUS_INVALIDATE, 0, 0, 16'h0000, 1'b0};
    tbl[4] = '{'{1'b1, 1'b0, 16'h0A1C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 2, 1'b0}, BUS_READEXCLUSIVE, 0, 4, 16'h0000, 1'b0};
    tbl[5] = '{'{1'b0, 1'b0, 16'h0B31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h3FF, 0, 1'b0}, NONE, 0, 0, 16'h0000, 1'b0};
    tbl[6] = '{'{1'b1, 1'b1, 16'h0C62, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1, 1'b0}, BUS_READEXCLUSIVE, 0, 4, 16'h0000, 1'b0};
    reset = 1'b0; cpuRead = 1'b0; cpuWrite = 1'b0; cpuAddress = '0; cpuDataOut = '0; cpuHit = 1'b0;
    writeBackRequired = 1'b0; invalidateRequired = 1'b0; protocolStateIn = MODIFIED; cacheTagOut = '0;
    busGrant = 1'b0; ramDataIn = '0; ramAck = 1'b1;
    repeat (2) @(posedge clock);
    #1 check("reset_outputs", 64'(outv()), 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1 ramAck = 1'b0;
    @(negedge clock) check("idle_outputs", 64'(outv()), 0);
    @(posedge clock);
    #1;
    for (int i = 0; i < 7; i++) begin
      run(tbl[i].t);
      check($sformatf("tbl%0d_cmd", i), 64'(cmd_log.size() != 0 ? cmd_log[0] : 18'(NONE)), 64'(tbl[i].e_cmd));
      check($sformatf("tbl%0d_nwb", i), 64'(wb_log.size()), 64'(tbl[i].e_nwb));
      check($sformatf("tbl%0d_nfill", i), 64'(rd_log.size()), 64'(tbl[i].e_nfill));
      if (tbl[i].chk_word) check($sformatf("tbl%0d_word", i), 64'(cpl_word), 64'(tbl[i].e_word));
    end
    // Reset in the middle of a fill: abort immediately, counter back to word 0.
    cpuRead = 1'b1; cpuWrite = 1'b0; cpuAddress = 16'h0200; cpuHit = 1'b0; invalidateRequired = 1'b0;
    writeBackRequired = 1'b0; busGrant = 1'b1; ramAck = 1'b1; ramDataIn = 16'hBEEF;
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge clock);
      if (ramRead && ramAck) n++;
    end
    check("abort_acks_seen", 64'(n), 2);
    reset = 1'b0;
    #1;
    check("abort_outputs", 64'(outv()), 0);
    check("abort_counter", 64'(cacheOffset), 0);
    cpuRead = 1'b0; busGrant = 1'b0; ramAck = 1'b0;
    @(posedge clock);
    #1 check("abort_no_write", 64'(outv()), 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    run('{1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 0, 1'b0});
    for (int i = 0; i < 40; i++) begin
      r.wr = 1'($urandom); r.both = r.wr & 1'($urandom); r.addr = 16'($urandom);
      r.hit0 = 1'($urandom); r.inv0 = 1'($urandom); r.hitg = 1'($urandom); r.invg = 1'($urandom);
      r.wb = 1'($urandom); r.vtag = 10'($urandom); r.gdly = $urandom_range(0, 4); r.rand_ack = 1'b1;
      run(r);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
